// File: rtl/uart_tx_sched.sv
// Shares one UART transmitter between NREQ byte requesters and sequences its register writes.
// Build option: define UART_TXSCHED_FIXPRIO_EN for fixed priority (lowest index wins) instead of round-robin.
`timescale 1ns/1ps
module uart_tx_sched #(
  parameter int          NREQ     = 4,
  parameter logic [15:0] BAUD_DEF = 16'd103,
  parameter logic [15:0] CON_DEF  = 16'h0003,
  parameter int          TMO_CYC  = 20000
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              cfg_go,
  input  logic [15:0]       cfg_baud,
  input  logic [15:0]       cfg_con,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              uart_baud_wr,
  output logic              uart_con_wr,
  output logic              uart_txbuf_wr,
  output logic [15:0]       icb_wdat,
  input  logic [15:0]       uart_con,
  output logic [2:0]        grant_id,
  output logic              busy,
  output logic              tmo_err,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_CFG_BAUD = 3'd0;
  localparam logic [2:0] S_CFG_CON  = 3'd1;
  localparam logic [2:0] S_IDLE     = 3'd2;
  localparam logic [2:0] S_LOAD     = 3'd3;
  localparam logic [2:0] S_WAIT     = 3'd4;
  localparam logic [2:0] S_CLR      = 3'd5;

  localparam logic [15:0] TMO_LAST = 16'(TMO_CYC - 1);

  logic [2:0]  state;
  logic [2:0]  state_n;
  logic [15:0] baud_q;
  logic [15:0] con_q;
  logic        go_pend;
  logic [15:0] tmo_cnt;
  logic        win_found;
  logic [2:0]  win_idx;
  logic [7:0]  win_data;
  logic        pending;
  logic        unused_con;

  assign pending    = uart_con[15];
  assign unused_con = ^uart_con[14:0];
  assign state_dbg  = state;

`ifdef UART_TXSCHED_FIXPRIO_EN
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end
`else
  logic [2:0] rr_ptr;

  // First pass looks at indices at or above rr_ptr; the second pass supplies the wrap-around winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i] && (3'(i) >= rr_ptr)) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!win_found && req_valid[i]) begin
        win_found = 1'b1;
        win_idx   = 3'(i);
      end
    end
  end
`endif

  always_comb begin
    win_data = 8'h00;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == 3'(i)) win_data = req_data[8*i +: 8];
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      S_CFG_BAUD: state_n = S_CFG_CON;
      S_CFG_CON:  state_n = S_IDLE;
      S_IDLE: begin
        if (cfg_go || go_pend)  state_n = S_CFG_BAUD;
        else if (|req_valid)    state_n = S_LOAD;
      end
      S_LOAD:     state_n = win_found ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (pending || (tmo_cnt == TMO_LAST)) state_n = S_CLR;
      end
      S_CLR:      state_n = S_IDLE;
      default:    state_n = S_CFG_BAUD;
    endcase
  end

  // Handshake: a requester holds req_valid and its byte until it sees its one-cycle
  // req_ready pulse; the byte is taken in that cycle. Valid may drop before the grant.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state         <= S_CFG_BAUD;
      baud_q        <= BAUD_DEF;
      con_q         <= CON_DEF;
      go_pend       <= 1'b0;
      tmo_cnt       <= 16'd0;
      req_ready     <= '0;
      uart_baud_wr  <= 1'b0;
      uart_con_wr   <= 1'b0;
      uart_txbuf_wr <= 1'b0;
      icb_wdat      <= 16'h0000;
      grant_id      <= 3'd0;
      busy          <= 1'b0;
      tmo_err       <= 1'b0;
`ifndef UART_TXSCHED_FIXPRIO_EN
      rr_ptr        <= 3'd0;
`endif
    end else begin
      state         <= state_n;
      busy          <= (state_n != S_IDLE);
      req_ready     <= '0;
      uart_baud_wr  <= 1'b0;
      uart_con_wr   <= 1'b0;
      uart_txbuf_wr <= 1'b0;
      icb_wdat      <= 16'h0000;

      if (cfg_go) begin
        baud_q  <= cfg_baud;
        con_q   <= cfg_con;
        tmo_err <= 1'b0;
      end

      if (state == S_IDLE)  go_pend <= 1'b0;
      else if (cfg_go)      go_pend <= 1'b1;

      case (state)
        S_CFG_BAUD: begin
          uart_baud_wr <= 1'b1;
          icb_wdat     <= baud_q;
        end
        S_CFG_CON: begin
          uart_con_wr <= 1'b1;
          icb_wdat    <= (con_q & 16'h03FF) | 16'h0001;
        end
        S_LOAD: begin
          if (win_found) begin
            uart_txbuf_wr <= 1'b1;
            icb_wdat      <= {8'h00, win_data};
            req_ready     <= NREQ'(1) << win_idx;
            grant_id      <= win_idx;
            tmo_cnt       <= 16'd0;
`ifndef UART_TXSCHED_FIXPRIO_EN
            rr_ptr        <= (win_idx == 3'(NREQ - 1)) ? 3'd0 : win_idx + 3'd1;
`endif
          end
        end
        S_WAIT: begin
          if (!pending) begin
            if (tmo_cnt == TMO_LAST)      tmo_err <= 1'b1;
            else if (tmo_cnt != 16'hFFFF) tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_CLR: begin
          // bit10 clears the UART's tx-pending flag
          uart_con_wr <= 1'b1;
          icb_wdat    <= (con_q & 16'h03FF) | 16'h0401;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: reset config, grants, timeout, reconfiguration, reset mid-transfer.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 20;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b1;
  logic              cfg_go = 1'b0;
  logic [15:0]       cfg_baud = 16'h0000;
  logic [15:0]       cfg_con = 16'h0000;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              uart_baud_wr;
  logic              uart_con_wr;
  logic              uart_txbuf_wr;
  logic [15:0]       icb_wdat;
  logic [15:0]       uart_con = 16'h0000;
  logic [2:0]        grant_id;
  logic              busy;
  logic              tmo_err;
  logic [2:0]        state_dbg;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  uart_tx_sched #(
    .NREQ(NREQ), .BAUD_DEF(16'd103), .CON_DEF(16'h0003), .TMO_CYC(TMO)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .cfg_go(cfg_go), .cfg_baud(cfg_baud),
    .cfg_con(cfg_con), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .uart_baud_wr(uart_baud_wr), .uart_con_wr(uart_con_wr), .uart_txbuf_wr(uart_txbuf_wr),
    .icb_wdat(icb_wdat), .uart_con(uart_con), .grant_id(grant_id), .busy(busy),
    .tmo_err(tmo_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic start_req(input int idx, input logic [7:0] data);
    req_valid = '0;
    req_valid[idx] = 1'b1;
    req_data[8*idx +: 8] = data;
  endtask

  task automatic check_cfg_seq(input string tag, input logic [15:0] baud, input logic [15:0] con);
    tick();
    check({tag, "_baud_wr"}, uart_baud_wr, 1);
    check({tag, "_baud_dat"}, icb_wdat, baud);
    tick();
    check({tag, "_con_wr"}, uart_con_wr, 1);
    check({tag, "_con_dat"}, icb_wdat, con);
  endtask

  initial begin
    // reset state
    tick(3);
    check("rst_busy", busy, 0);
    check("rst_strobes", {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, 0);
    check("rst_wdat", icb_wdat, 0);
    check("rst_ready", req_ready, 0);
    check("rst_grant", grant_id, 0);
    check("rst_tmo", tmo_err, 0);
    check("rst_state", state_dbg, 0);

    sys_rst = 1'b0;
    check_cfg_seq("boot", 16'd103, 16'h0003);
    tick();
    check("boot_idle_busy", busy, 0);
    check("boot_idle_strobe", uart_con_wr, 0);

    // single request on requester 2
    start_req(2, 8'hA5);
    tick();
    check("single_lat1_ready", req_ready, 0);
    tick();
    check("single_ready", req_ready, 4'b0100);
    check("single_txbuf_wr", uart_txbuf_wr, 1);
    check("single_wdat", icb_wdat, 16'h00A5);
    check("single_grant", grant_id, 2);
    req_valid = '0;
    uart_con = 16'h8000;
    check("single_busy", busy, 1);
    tick();
    check("single_wait_nostrobe", uart_con_wr, 0);
    tick();
    check("single_clr_wr", uart_con_wr, 1);
    check("single_clr_dat", icb_wdat, 16'h0403);
    uart_con = 16'h0000;
    tick();
    check("single_done_busy", busy, 0);

    // timeout on requester 3
    start_req(3, 8'h3C);
    tick(2);
    check("tmo_grant", grant_id, 3);
    check("tmo_ready", req_ready, 4'b1000);
    req_valid = '0;
    tick(TMO - 1);
    check("tmo_not_yet", tmo_err, 0);
    tick();
    check("tmo_set", tmo_err, 1);
    tick();
    check("tmo_clr_wr", uart_con_wr, 1);
    check("tmo_clr_dat", icb_wdat, 16'h0403);
    tick();
    check("tmo_sticky", tmo_err, 1);
    cfg_baud = 16'd103;
    cfg_con  = 16'h0003;
    cfg_go   = 1'b1;
    tick();
    cfg_go = 1'b0;
    check("tmo_cleared_by_go", tmo_err, 0);
    check("go_busy", busy, 1);
    check_cfg_seq("go_idle", 16'd103, 16'h0003);
    tick();

    // cfg_go during WAIT on requester 1; requester 0 waits behind the reconfiguration
    start_req(1, 8'h77);
    tick(2);
    check("gow_grant", grant_id, 1);
    check("gow_ready", req_ready, 4'b0010);
    check("gow_wdat", icb_wdat, 16'h0077);
    req_valid = '0;
    cfg_baud = 16'd51;
    cfg_con  = 16'h0005;
    cfg_go   = 1'b1;
    tick();
    cfg_go = 1'b0;
    uart_con = 16'h8000;
    start_req(0, 8'h99);
    tick();
    check("gow_wait_nostrobe", {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, 0);
    tick();
    check("gow_clr_wr", uart_con_wr, 1);
    check("gow_clr_dat", icb_wdat, 16'h0405);
    tick();
    check("gow_prio_ready", req_ready, 0);
    check("gow_prio_busy", busy, 1);
    check_cfg_seq("gow_cfg", 16'd51, 16'h0005);
    tick();
    check("gow_load_ready", req_ready, 0);
    tick();
    check("gow_next_ready", req_ready, 4'b0001);
    check("gow_next_wdat", icb_wdat, 16'h0099);
    req_valid = '0;
    tick(2);
    check("gow_next_clr_dat", icb_wdat, 16'h0405);
    uart_con = 16'h0000;
    tick();

    // sys_rst during WAIT
    start_req(2, 8'h5A);
    tick(2);
    check("rstw_grant", grant_id, 2);
    req_valid = '0;
    tick();
    sys_rst = 1'b1;
    tick();
    check("rstw_busy", busy, 0);
    check("rstw_strobes", {uart_baud_wr, uart_con_wr, uart_txbuf_wr}, 0);
    check("rstw_grant0", grant_id, 0);
    check("rstw_wdat", icb_wdat, 0);
    sys_rst = 1'b0;
    check_cfg_seq("rstw_boot", 16'd103, 16'h0003);
    tick();

    // valid dropped before LOAD
    start_req(1, 8'h11);
    tick();
    req_valid = '0;
    tick();
    check("drop_ready", req_ready, 0);
    check("drop_txbuf", uart_txbuf_wr, 0);
    check("drop_busy", busy, 0);

    // all four requesters held valid, pending flag already high on WAIT entry
`ifdef UART_TXSCHED_FIXPRIO_EN
    for (int g = 0; g < 5; g++) exp_q.push_back(3'd0);
`else
    exp_q.push_back(3'd0);
    exp_q.push_back(3'd1);
    exp_q.push_back(3'd2);
    exp_q.push_back(3'd3);
    exp_q.push_back(3'd0);
`endif
    req_valid = 4'hF;
    req_data  = 32'h13121110;
    uart_con  = 16'h8000;
    for (int g = 0; g < 5; g++) begin
      int cyc;
      logic [2:0] e;
      cyc = 0;
      do begin
        tick();
        cyc++;
      end while (req_ready == 0 && cyc < 10);
      check("rr_wait", (req_ready != 0), 1);
      e = exp_q.pop_front();
      check("rr_grant", grant_id, e);
      check("rr_ready", req_ready, 4'(1) << e);
      check("rr_wdat", icb_wdat, 16'h0010 + 16'(e));
    end
    req_valid = '0;
    tick(3);
    uart_con = 16'h0000;
    check("rr_end_busy", busy, 0);
    check("rr_end_tmo", tmo_err, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
